// File: rtl/output_collector.sv
// Output collector: buffers completed output-pixel groups in a small FIFO and serialises them
// one channel per beat onto a valid/ready stream with a flattened feature-map address.
module output_collector #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int NB_PAR_OUT         = 6,
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                               clk,
    input  logic                               arst_n_in,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [NB_PAR_OUT*DATA_WIDTH-1:0]   in_data,
    input  logic [31:0]                        in_x,
    input  logic [31:0]                        in_y,
    input  logic [31:0]                        in_ch,
    output logic                               stall,
    output logic                               overflow,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [31:0]                        out_ch,
    output logic [LOG2_OF_MEM_HEIGHT-1:0]      out_addr,
    output logic                               out_last,
    output logic                               done
);

    localparam int GroupW = NB_PAR_OUT * DATA_WIDTH;
    localparam int PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CntW   = PtrW + 1;
    localparam int LaneW  = (NB_PAR_OUT > 1) ? $clog2(NB_PAR_OUT) : 1;

    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0]  CntStall = CntW'(FIFO_DEPTH - 1);
    localparam logic [LaneW-1:0] LaneMax  = LaneW'(NB_PAR_OUT - 1);

    logic [GroupW-1:0] data_mem [FIFO_DEPTH];
    logic [31:0]       x_mem    [FIFO_DEPTH];
    logic [31:0]       y_mem    [FIFO_DEPTH];
    logic [31:0]       ch_mem   [FIFO_DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic [LaneW-1:0] lane_q;
    logic             stall_q, overflow_q, done_q;

    logic        not_empty, last_lane, fire, pop, push, drop, final_beat;
    logic [31:0] head_ch, head_x, head_y;
    logic [32:0] next_ch;
    logic [63:0] addr_full;

    always_comb begin
        not_empty = (count_q != '0);
        head_ch   = ch_mem[rd_ptr_q] + 32'(lane_q);
        head_x    = x_mem[rd_ptr_q];
        head_y    = y_mem[rd_ptr_q];
        next_ch   = {1'b0, head_ch} + 33'd1;
        // Lanes beyond the channel bound are skipped, so the last in-range lane closes the group.
        last_lane = (lane_q == LaneMax) || (next_ch >= 33'(OUTPUT_NB_CHANNELS));
        fire      = not_empty && out_ready;
        pop       = fire && last_lane;
        push      = in_valid && ((count_q != CntFull) || pop);
        drop      = in_valid && (count_q == CntFull) && !pop;
        final_beat = fire && (head_x == 32'(FEATURE_MAP_WIDTH - 1))
                          && (head_y == 32'(FEATURE_MAP_HEIGHT - 1))
                          && (head_ch == 32'(OUTPUT_NB_CHANNELS - 1));
        addr_full = (({32'b0, head_ch} * 64'(FEATURE_MAP_HEIGHT) + {32'b0, head_y})
                     * 64'(FEATURE_MAP_WIDTH)) + {32'b0, head_x};
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        out_valid = not_empty;
        out_data  = not_empty ? data_mem[rd_ptr_q][lane_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        out_ch    = not_empty ? head_ch : '0;
        out_addr  = not_empty ? addr_full[LOG2_OF_MEM_HEIGHT-1:0] : '0;
        out_last  = not_empty && last_lane;
        stall     = stall_q;
        overflow  = overflow_q;
        done      = done_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= in_data;
            x_mem[wr_ptr_q]    <= in_x;
            y_mem[wr_ptr_q]    <= in_y;
            ch_mem[wr_ptr_q]   <= in_ch;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_q     <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            stall_q <= (count_d >= CntStall);
            if (flush) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                lane_q     <= '0;
                overflow_q <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (fire) lane_q   <= last_lane ? '0 : lane_q + 1'b1;
                if (drop) overflow_q <= 1'b1;
                done_q <= final_beat;
            end
        end
    end

endmodule

// File: tb/tb_output_collector.sv
// Scoreboard bench for output_collector: directed groups queue their expected beats and a
// negedge monitor checks every handshake against the queue.
module tb_output_collector;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        flush;
    logic        in_valid;
    logic [191:0] in_data;
    logic [31:0] in_x, in_y, in_ch;
    logic        stall, overflow, out_valid, out_ready, out_last, done;
    logic [31:0] out_data, out_ch;
    logic [19:0] out_addr;

    output_collector dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_ch     (in_ch),
        .stall     (stall),
        .overflow  (overflow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] ch;
        logic [19:0] addr;
        logic        last;
        logic        fin;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    nbeats = 0;
    int    done_cnt = 0;
    bit    done_pend = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Hand-computed group: n beats, data d0.., channel ch0.., constant address.
    task automatic exp_group(input int d0, input int ch0, input int n, input int addr,
                             input bit fin);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = 32'(d0 + i);
            b.ch   = 32'(ch0 + i);
            b.addr = 20'(addr);
            b.last = (i == n - 1);
            b.fin  = fin && (i == n - 1);
            sb.push_back(b);
        end
    endtask

    task automatic push_grp(input int x, input int y, input int ch, input int d0);
        for (int i = 0; i < 6; i++) in_data[i*32 +: 32] = 32'(d0 + i);
        in_x = 32'(x);
        in_y = 32'(y);
        in_ch = 32'(ch);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d beats pending required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done_pend) begin
            check("done_after_final", {63'd0, done}, 64'd1);
            done_pend = 1'b0;
        end
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            nbeats++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got data %0d ch %0d required no beat",
                         out_data, out_ch);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_data", {32'd0, out_data}, {32'd0, e.data});
                check("beat_ch", {32'd0, out_ch}, {32'd0, e.ch});
                check("beat_addr", {44'd0, out_addr}, {44'd0, e.addr});
                check("beat_last", {63'd0, out_last}, {63'd0, e.last});
                if (e.fin) done_pend = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb0;
        arst_n_in = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_x = '0;
        in_y = '0;
        in_ch = '0;
        out_ready = 1'b0;
        #3;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_out_addr", {44'd0, out_addr}, 64'd0);
        @(posedge clk);
        #1 arst_n_in = 1'b1;
        @(posedge clk);
        #1;

        // 1: single group, streaming one cycle after push
        out_ready = 1'b1;
        exp_group(10, 6, 6, 2051, 1'b0);
        nb0 = nbeats;
        push_grp(3, 2, 6, 10);
        check("t1_latency_valid", {63'd0, out_valid}, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("t1_beats", 64'(nbeats - nb0), 64'd6);
        check("t1_empty_after", {63'd0, out_valid}, 64'd0);

        // 2: back-pressure, stall and overflow
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            exp_group(100 * (g + 1), 0, 6, g + 1, 1'b0);
            push_grp(g + 1, 0, 0, 100 * (g + 1));
            if (g == 1) check("t2_stall_low_2", {63'd0, stall}, 64'd0);
            if (g == 2) check("t2_stall_high_3", {63'd0, stall}, 64'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("t2_hold_valid", {63'd0, out_valid}, 64'd1);
        check("t2_hold_data", {32'd0, out_data}, 64'd100);
        check("t2_hold_ch", {32'd0, out_ch}, 64'd0);
        check("t2_no_ovf_yet", {63'd0, overflow}, 64'd0);
        push_grp(5, 0, 0, 500);
        check("t2_overflow", {63'd0, overflow}, 64'd1);
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("t2_no_fifth", {63'd0, out_valid}, 64'd0);
        check("t2_overflow_sticky", {63'd0, overflow}, 64'd1);

        // 3: push on full FIFO in the same cycle as the last-lane pop
        out_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("t3_flush_clears_ovf", {63'd0, overflow}, 64'd0);
        for (int g = 0; g < 4; g++) begin
            exp_group(1000 + 100 * g, 0, 6, 10 + g, 1'b0);
            push_grp(10 + g, 0, 0, 1000 + 100 * g);
        end
        check("t3_stall_full", {63'd0, stall}, 64'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        exp_group(2000, 0, 6, 20, 1'b0);
        push_grp(20, 0, 0, 2000);
        check("t3_no_overflow", {63'd0, overflow}, 64'd0);
        drain();
        check("t3_stall_clear", {63'd0, stall}, 64'd0);

        // 4: channel bound truncates the group
        exp_group(40, 60, 4, 0, 1'b0);
        nb0 = nbeats;
        push_grp(0, 0, 60, 40);
        drain();
        check("t4_beats", 64'(nbeats - nb0), 64'd4);

        // 5: final pixel of the map raises done
        exp_group(50, 60, 4, 1048575, 1'b1);
        push_grp(1023, 1023, 60, 50);
        drain();
        repeat (2) @(posedge clk);
        #1;

        // 6a: flush mid-group
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            exp_group(3000 + 100 * g, 0, 6, g, 1'b0);
            push_grp(g, 0, 0, 3000 + 100 * g);
        end
        push_grp(9, 0, 0, 3900);
        check("t6_overflow_set", {63'd0, overflow}, 64'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        flush = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 flush = 1'b0;
        check("t6_flush_valid", {63'd0, out_valid}, 64'd0);
        check("t6_flush_ovf", {63'd0, overflow}, 64'd0);
        check("t6_flush_stall", {63'd0, stall}, 64'd0);
        exp_group(4000, 0, 6, 7, 1'b0);
        push_grp(7, 0, 0, 4000);
        check("t6_restart_lane0", {32'd0, out_data}, 64'd4000);
        out_ready = 1'b1;
        drain();

        // 6b: reset mid-group on the final pixel, no done may follow
        out_ready = 1'b0;
        exp_group(5000, 58, 6, 1048575, 1'b1);
        push_grp(1023, 1023, 58, 5000);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        arst_n_in = 1'b0;
        sb.delete();
        #1;
        check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        check("t6_rst_data", {32'd0, out_data}, 64'd0);
        check("t6_rst_ovf", {63'd0, overflow}, 64'd0);
        @(posedge clk);
        #1 arst_n_in = 1'b1;
        exp_group(6000, 0, 6, 2, 1'b0);
        push_grp(2, 0, 0, 6000);
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("done_pulse_count", 64'(done_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_collector.md
Name: output_collector

Overview:
- Sits directly downstream of the convolution controller/datapath.
- Captures each completed output-pixel group on a single-cycle `in_valid` pulse. A group is NB_PAR_OUT parallel output-channel results plus their x/y/ch coordinates.
- Buffers groups in a small FIFO, then serialises them one channel per beat onto a valid/ready stream toward the host, with a flattened memory address.
- Provides back-pressure (`stall`), overflow detection and an end-of-map `done` pulse.

Parameters:
- LOG2_OF_MEM_HEIGHT, 20, width of `out_addr`.
- FEATURE_MAP_WIDTH, 1024, pixels per row.
- FEATURE_MAP_HEIGHT, 1024, rows per map.
- OUTPUT_NB_CHANNELS, 64, total output channels.
- NB_PAR_OUT, 6, output channels delivered per group.
- DATA_WIDTH, 32, width of each result.
- FIFO_DEPTH, 4, group entries buffered (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- arst_n_in  in  1  reset; asynchronous assert, active-low.
- flush  in  1  synchronous clear of FIFO, lane counter and overflow.
- in_valid  in  1  one-cycle pulse: group present on the in_* ports.
- in_data  in  NB_PAR_OUT*DATA_WIDTH  results; lane i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_x  in  32  pixel x.
- in_y  in  32  pixel y.
- in_ch  in  32  base output channel of the group.
- stall  out  1  high when the FIFO holds ≥ FIFO_DEPTH-1 entries.
- overflow  out  1  sticky; set when a group is dropped.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_WIDTH  current lane result.
- out_ch  out  32  in_ch + lane.
- out_addr  out  LOG2_OF_MEM_HEIGHT  flattened address.
- out_last  out  1  high on the last lane of a group.
- done  out  1  one-cycle pulse after the final element of the map is accepted.

Behaviour:
- Reset values (asynchronous):
  - FIFO count, write/read pointers and lane counter are 0.
  - `overflow`, `done` and `stall` are 0; `out_valid` is 0.
  - `out_data`, `out_ch` and `out_addr` are 0 while the FIFO is empty.
- Push:
  - A group is accepted when `in_valid` is high and either count < FIFO_DEPTH or a pop completes in the same cycle.
  - The whole group (data, x, y, ch) is written at the rising edge.
- Drop: if `in_valid` is high, count == FIFO_DEPTH and there is no pop that cycle, the group is discarded and `overflow` is set at that edge. `overflow` clears only on reset or `flush`.
- Output path:
  - `out_valid` = (count != 0).
  - All out_* ports are combinational from the head entry and the lane counter.
  - Latency from push edge to `out_valid` high is 1 cycle when the FIFO was empty.
- Handshake:
  - A beat transfers when `out_valid` and `out_ready` are both high.
  - The lane counter increments per beat, 0..NB_PAR_OUT-1.
  - On the beat with lane == NB_PAR_OUT-1 (`out_last` high), the lane counter wraps to 0, the read pointer advances and the entry is popped.
  - Data must stay stable while `out_valid` is high and `out_ready` is low.
- Address:
  - `out_addr` = ((out_ch*FEATURE_MAP_HEIGHT + y)*FEATURE_MAP_WIDTH + x).
  - Computed in 64 bits, then truncated to the low LOG2_OF_MEM_HEIGHT bits.
- Channel bound: lanes with out_ch ≥ OUTPUT_NB_CHANNELS are skipped.
  - The lane counter jumps straight to pop; there is no beat for those lanes.
  - `out_last` is asserted on the last in-range lane instead.
- done: pulses high in the cycle after the handshake of the beat with x == FEATURE_MAP_WIDTH-1, y == FEATURE_MAP_HEIGHT-1 and out_ch == OUTPUT_NB_CHANNELS-1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- flush:
  - Has priority over push and pop in the same cycle.
  - The next cycle has count 0, lane 0, `out_valid` 0 and `overflow` 0.
- stall is registered from the next-state count. It is high one cycle after the count reaches FIFO_DEPTH-1 and low one cycle after it falls below.
- Reset mid-transfer: all state clears immediately; the partial group is lost and no `done` is emitted.

Test Plan:
1. Single group, in_x=3, in_y=2, in_ch=6, data lanes 10..15, out_ready tied 1, W=H=1024 → 6 beats on consecutive cycles starting 1 cycle after the push.
   - `out_ch` = 6..11 and `out_data` = 10..15.
   - `out_addr`[0] = (6*1024+2)*1024+3 mod 2^20 = 2051.
   - `out_last` high only on beat 6.
2. Back-pressure: push 4 groups with out_ready=0 → `stall` high after the 3rd push; count is 4 and `out_valid` is held with stable data. A 5th push sets `overflow`=1 and the 5 pushed groups are not all delivered: exactly 4 groups × 6 beats come out once out_ready=1.
3. Push on a full FIFO in the same cycle as the last-lane pop → no overflow; the new group appears after the remaining entries.
4. Channel bound with OUTPUT_NB_CHANNELS=64, in_ch=60 → exactly 4 beats (ch 60..63), `out_last` on ch 63.
5. Final pixel x=1023, y=1023, in_ch=60 → `done` pulses once, one cycle after the ch 63 handshake.
6. Assert `flush` (then separately `arst_n_in` low) mid-group after 2 beats → `out_valid` 0 next cycle, `overflow` cleared; a subsequent push restarts at lane 0.
